// File: rtl/rs_generic_pkg.sv
// Shared defaults and types for the reservation station.
// rv_structs carries the default geometry and the record layouts at that
// geometry; rs_generic_pkg carries the issue-register state encoding.
package rv_structs;

    localparam int RS_DEPTH   = 8;
    localparam int RS_NUM_CDB = 2;
    localparam int RS_ROB_W   = 5;
    localparam int RS_XLEN    = 32;
    localparam int RS_OP_W    = 3;

    // One station entry at the default geometry.
    typedef struct packed {
        logic                valid;
        logic [RS_ROB_W-1:0] dest_rob;
        logic [RS_OP_W-1:0]  op;
        logic [RS_ROB_W-1:0] src1_rob;
        logic [RS_XLEN-1:0]  src1_value;
        logic                src1_valid;
        logic [RS_ROB_W-1:0] src2_rob;
        logic [RS_XLEN-1:0]  src2_value;
        logic                src2_valid;
        logic [RS_XLEN-1:0]  pc;
    } rs_entry_t;

    // One common-data-bus broadcast.
    typedef struct packed {
        logic [RS_ROB_W-1:0] dest_rob;
        logic [RS_XLEN-1:0]  value;
        logic                valid;
    } cdb_port_t;

endpackage

package rs_generic_pkg;

    // Issue register occupancy; ISS_FULL is exactly issue_valid.
    typedef enum logic {
        ISS_EMPTY = 1'b0,
        ISS_FULL  = 1'b1
    } iss_state_t;

endpackage

// File: rtl/rs_generic_if.sv
// Bus bundle between the dispatcher/functional unit side (master) and the
// reservation station (slave).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. valid never depends combinationally on ready; once raised,
// valid and its payload stay stable until the transfer happens (the only
// exceptions are flush and reset, which abort the transfer).
interface rs_generic_if
    import rs_generic_pkg::*;
#(
    parameter int NUM_CDB = 2,
    parameter int ROB_W   = 5,
    parameter int XLEN    = 32,
    parameter int OP_W    = 3,
    parameter int CNT_W   = 4
);
    logic                     flush;

    logic                     alloc_valid;
    logic                     alloc_ready;
    logic [ROB_W-1:0]         alloc_dest_rob;
    logic [OP_W-1:0]          alloc_op;
    logic [XLEN-1:0]          alloc_pc;
    logic [ROB_W-1:0]         alloc_src1_rob;
    logic [XLEN-1:0]          alloc_src1_value;
    logic                     alloc_src1_valid;
    logic [ROB_W-1:0]         alloc_src2_rob;
    logic [XLEN-1:0]          alloc_src2_value;
    logic                     alloc_src2_valid;

    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*ROB_W-1:0] cdb_rob;
    logic [NUM_CDB*XLEN-1:0]  cdb_value;

    logic                     issue_valid;
    logic                     issue_ready;
    logic [ROB_W-1:0]         issue_rob;
    logic [OP_W-1:0]          issue_op;
    logic [XLEN-1:0]          issue_src1;
    logic [XLEN-1:0]          issue_src2;
    logic [XLEN-1:0]          issue_pc;

    logic [CNT_W-1:0]         count;
    iss_state_t               state;

    modport master (
        output flush, alloc_valid, alloc_dest_rob, alloc_op, alloc_pc,
               alloc_src1_rob, alloc_src1_value, alloc_src1_valid,
               alloc_src2_rob, alloc_src2_value, alloc_src2_valid,
               cdb_valid, cdb_rob, cdb_value, issue_ready,
        input  alloc_ready, issue_valid, issue_rob, issue_op, issue_src1,
               issue_src2, issue_pc, count, state
    );

    modport slave (
        input  flush, alloc_valid, alloc_dest_rob, alloc_op, alloc_pc,
               alloc_src1_rob, alloc_src1_value, alloc_src1_valid,
               alloc_src2_rob, alloc_src2_value, alloc_src2_valid,
               cdb_valid, cdb_rob, cdb_value, issue_ready,
        output alloc_ready, issue_valid, issue_rob, issue_op, issue_src1,
               issue_src2, issue_pc, count, state
    );

endinterface

// File: rtl/rs_generic_wakeup.sv
// Operand capture for one tag/value pair: an operand that is still waiting
// picks up the value of the lowest-numbered CDB port broadcasting its tag.
module rs_wakeup #(
    parameter int NUM_CDB = 2,
    parameter int ROB_W   = 5,
    parameter int XLEN    = 32
) (
    input  logic [ROB_W-1:0]         tag,
    input  logic [XLEN-1:0]          value,
    input  logic                     ready,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0] cdb_rob,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_value,
    output logic [XLEN-1:0]          value_next,
    output logic                     ready_next
);

    // Scan from the highest port down so the lowest matching port is written last.
    always_comb begin
        value_next = value;
        ready_next = ready;
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
            if (!ready && cdb_valid[p] && (cdb_rob[p*ROB_W +: ROB_W] == tag)) begin
                value_next = cdb_value[p*XLEN +: XLEN];
                ready_next = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_generic.sv
// Generic reservation station: age-ordered compacted entries, CDB wakeup,
// oldest-ready select into a registered issue slot.
module rs_generic
    import rv_structs::*;
    import rs_generic_pkg::*;
#(
    parameter int DEPTH   = RS_DEPTH,
    parameter int NUM_CDB = RS_NUM_CDB,
    parameter int ROB_W   = RS_ROB_W,
    parameter int XLEN    = RS_XLEN,
    parameter int OP_W    = RS_OP_W
) (
    input logic         clk,
    input logic         rst,
    rs_generic_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic             valid;
        logic [ROB_W-1:0] dest_rob;
        logic [OP_W-1:0]  op;
        logic [ROB_W-1:0] src1_rob;
        logic [XLEN-1:0]  src1_value;
        logic             src1_valid;
        logic [ROB_W-1:0] src2_rob;
        logic [XLEN-1:0]  src2_value;
        logic             src2_valid;
        logic [XLEN-1:0]  pc;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    entry_t           woke  [DEPTH+1];   // top slot is the empty filler for shifts
    entry_t           new_ent;
    logic [XLEN-1:0]  s1_val [DEPTH];
    logic [XLEN-1:0]  s2_val [DEPTH];
    logic [DEPTH-1:0] s1_rdy;
    logic [DEPTH-1:0] s2_rdy;
    logic [XLEN-1:0]  a1_val;
    logic [XLEN-1:0]  a2_val;
    logic             a1_rdy;
    logic             a2_rdy;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] wr_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             alloc_ok;
    logic             do_alloc;
    logic             do_load;

    iss_state_t       state_q;
    iss_state_t       state_d;
    logic [ROB_W-1:0] iss_rob;
    logic [OP_W-1:0]  iss_op;
    logic [XLEN-1:0]  iss_src1;
    logic [XLEN-1:0]  iss_src2;
    logic [XLEN-1:0]  iss_pc;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        rs_wakeup #(.NUM_CDB(NUM_CDB), .ROB_W(ROB_W), .XLEN(XLEN)) u_src1 (
            .tag        (ent_q[g].src1_rob),
            .value      (ent_q[g].src1_value),
            .ready      (ent_q[g].src1_valid),
            .cdb_valid  (bus.cdb_valid),
            .cdb_rob    (bus.cdb_rob),
            .cdb_value  (bus.cdb_value),
            .value_next (s1_val[g]),
            .ready_next (s1_rdy[g])
        );
        rs_wakeup #(.NUM_CDB(NUM_CDB), .ROB_W(ROB_W), .XLEN(XLEN)) u_src2 (
            .tag        (ent_q[g].src2_rob),
            .value      (ent_q[g].src2_value),
            .ready      (ent_q[g].src2_valid),
            .cdb_valid  (bus.cdb_valid),
            .cdb_rob    (bus.cdb_rob),
            .cdb_value  (bus.cdb_value),
            .value_next (s2_val[g]),
            .ready_next (s2_rdy[g])
        );
    end

    // Allocation bypass: operands arriving on the CDB in the allocation cycle.
    rs_wakeup #(.NUM_CDB(NUM_CDB), .ROB_W(ROB_W), .XLEN(XLEN)) u_alloc1 (
        .tag        (bus.alloc_src1_rob),
        .value      (bus.alloc_src1_value),
        .ready      (bus.alloc_src1_valid),
        .cdb_valid  (bus.cdb_valid),
        .cdb_rob    (bus.cdb_rob),
        .cdb_value  (bus.cdb_value),
        .value_next (a1_val),
        .ready_next (a1_rdy)
    );
    rs_wakeup #(.NUM_CDB(NUM_CDB), .ROB_W(ROB_W), .XLEN(XLEN)) u_alloc2 (
        .tag        (bus.alloc_src2_rob),
        .value      (bus.alloc_src2_value),
        .ready      (bus.alloc_src2_valid),
        .cdb_valid  (bus.cdb_valid),
        .cdb_rob    (bus.cdb_rob),
        .cdb_value  (bus.cdb_value),
        .value_next (a2_val),
        .ready_next (a2_rdy)
    );

    // Entries with this edge's CDB captures applied, plus the incoming entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i]            = ent_q[i];
            woke[i].src1_value = s1_val[i];
            woke[i].src1_valid = s1_rdy[i];
            woke[i].src2_value = s2_val[i];
            woke[i].src2_valid = s2_rdy[i];
        end
        woke[DEPTH] = '0;
        new_ent            = '0;
        new_ent.valid      = 1'b1;
        new_ent.dest_rob   = bus.alloc_dest_rob;
        new_ent.op         = bus.alloc_op;
        new_ent.pc         = bus.alloc_pc;
        new_ent.src1_rob   = bus.alloc_src1_rob;
        new_ent.src1_value = a1_val;
        new_ent.src1_valid = a1_rdy;
        new_ent.src2_rob   = bus.alloc_src2_rob;
        new_ent.src2_value = a2_val;
        new_ent.src2_valid = a2_rdy;
    end

    // Select the oldest entry whose operands are ready in registered state only.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_q[i].valid && ent_q[i].src1_valid && ent_q[i].src2_valid) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Issue-register FSM next state and the allocate/load decisions.
    always_comb begin
        alloc_ok = (count_q != CNT_W'(DEPTH)) && !bus.flush;
        do_alloc = bus.alloc_valid && alloc_ok;
        do_load  = sel_found && !bus.flush &&
                   ((state_q == ISS_EMPTY) || bus.issue_ready);
        state_d  = state_q;
        if (bus.flush) begin
            state_d = ISS_EMPTY;
        end else if (do_load) begin
            state_d = ISS_FULL;
        end else if ((state_q == ISS_FULL) && bus.issue_ready) begin
            state_d = ISS_EMPTY;
        end
    end

    // Next entry array: compact over the departing entry, then append.
    always_comb begin
        wr_idx  = count_q - CNT_W'(do_load);
        count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_load);
        for (int i = 0; i < DEPTH; i++) begin
            if (do_load && (i >= int'(sel_idx))) begin
                ent_d[i] = woke[i+1];
            end else begin
                ent_d[i] = woke[i];
            end
            if (do_alloc && (wr_idx == CNT_W'(i))) begin
                ent_d[i] = new_ent;
            end
            if (bus.flush) begin
                ent_d[i].valid = 1'b0;
            end
        end
        if (bus.flush) begin
            count_d = '0;
        end
    end

    // Entry storage and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q <= count_d;
        end
    end

    // Issue-register FSM state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ISS_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue payload; held while the functional unit stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_rob  <= '0;
            iss_op   <= '0;
            iss_src1 <= '0;
            iss_src2 <= '0;
            iss_pc   <= '0;
        end else if (do_load) begin
            iss_rob  <= ent_q[sel_idx].dest_rob;
            iss_op   <= ent_q[sel_idx].op;
            iss_src1 <= ent_q[sel_idx].src1_value;
            iss_src2 <= ent_q[sel_idx].src2_value;
            iss_pc   <= ent_q[sel_idx].pc;
        end
    end

    assign bus.alloc_ready = alloc_ok;
    assign bus.issue_valid = (state_q == ISS_FULL);
    assign bus.issue_rob   = iss_rob;
    assign bus.issue_op    = iss_op;
    assign bus.issue_src1  = iss_src1;
    assign bus.issue_src2  = iss_src2;
    assign bus.issue_pc    = iss_pc;
    assign bus.count       = count_q;
    assign bus.state       = state_q;

endmodule

// File: doc/rs_generic.md
RS_GENERIC -- requirements
Module: rs_generic

Interface
REQ-001 Parameter DEPTH, 8, number of station entries (2..16).
REQ-002 Parameter NUM_CDB, 2, number of common-data-bus broadcast ports (1..4).
REQ-003 Parameter ROB_W, 5, ROB tag width.
REQ-004 Parameter XLEN, 32, operand/data width.
REQ-005 Parameter OP_W, 3, operation code width.
REQ-006 clk  input  1  single clock; all state rising-edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 flush  input  1  discard all entries and the issue register.
REQ-009 alloc_valid / alloc_ready  input / output  1 / 1  allocation handshake.
REQ-010 alloc_dest_rob, alloc_op, alloc_pc  input  ROB_W, OP_W, XLEN  destination tag, op, branch PC.
REQ-011 alloc_src{1,2}_rob, alloc_src{1,2}_value, alloc_src{1,2}_valid  input  ROB_W, XLEN, 1  operand tag, value, ready flag.
REQ-012 cdb_valid, cdb_rob, cdb_value  input  NUM_CDB, NUM_CDB*ROB_W, NUM_CDB*XLEN  broadcast ports, port i in slice i.
REQ-013 issue_valid / issue_ready  output / input  1 / 1  issue handshake to the functional unit.
REQ-014 issue_rob, issue_op, issue_src1, issue_src2, issue_pc  output  ROB_W, OP_W, XLEN, XLEN, XLEN  issued instruction.
REQ-015 count  output  $clog2(DEPTH+1)  occupied station entries, excluding the issue register.

Function
REQ-016 Entries are kept compacted in age order: index 0 is the oldest, and indices 0..count-1 are valid.
REQ-017 alloc_ready = (count != DEPTH) && !flush; allocation occurs on the edge where alloc_valid && alloc_ready.
REQ-018 An allocated entry is written at index (count minus 1 if an entry departs on the same edge, else count).
REQ-019 Wakeup: each edge, every valid entry operand with valid=0 whose tag equals cdb_rob[i] with cdb_valid[i]=1 captures cdb_value[i] and sets valid=1.
REQ-020 Allocation bypass: an alloc operand with valid=0 matching an active CDB port in the allocation cycle is stored already valid with the CDB value.
REQ-021 If several CDB ports match one tag, the lowest port index wins.
REQ-022 Select: the lowest-index entry with both operands valid is the candidate; the select logic sees only state as of the current cycle, with no same-cycle wakeup forwarding into select.
REQ-023 The issue register loads the candidate when it is empty, or when issue_valid && issue_ready. A loaded candidate is removed and entries above it shift down one index.
REQ-024 Issue outputs are registered and hold stable while issue_valid && !issue_ready.
REQ-025 Minimum latency: allocation edge E0 with both operands ready leads to issue_valid=1 in the cycle after E1.
REQ-026 A CDB hit at edge E makes the entry eligible for select in the cycle after E.
REQ-027 Full: when count==DEPTH, alloc_ready=0 even if an issue departs that cycle; no same-cycle reuse.
REQ-028 Empty or no ready candidate: the issue register does not load; issue_valid falls after handshake completion.
REQ-029 flush=1 at an edge clears all entries, count, and issue_valid; allocation and issue loads in that cycle are ignored.
REQ-030 count updates as +1 on allocation, -1 on departure, unchanged when both or neither occur, and never exceeds DEPTH.

Reset
REQ-031 rst=0 asynchronously clears all entry valid bits, count=0, issue_valid=0, and issue data outputs to 0; alloc_ready=1 after release.
REQ-032 Reset asserted mid-operation discards all entries and any pending issue, with no partial state retained.

Structure
REQ-033 rv_structs holds the RS_DEPTH/NUM_CDB defaults and the typedef rs_entry_t (dest_rob, op, src tags, values, valid bits, pc, entry valid).
REQ-034 rv_structs holds the typedef cdb_port_t (dest_rob, value, valid).
REQ-035 Per-entry operand capture is a sub-module rs_wakeup, instantiated per entry (one tag/value pair in, NUM_CDB ports compared).

Verification
REQ-036 Allocate A (both operands ready, rob 3) with issue_ready=1 -> issue_valid with issue_rob=3 in the cycle after the second edge; count returns to 0.
REQ-037 Allocate A (src1 waits on rob 7), then B ready; CDB port 1 broadcasts rob 7 value 0xDEAD -> B issues first, then A with issue_src1=0xDEAD.
REQ-038 Fill all 8 entries with issue_ready=0 -> alloc_ready=0 and count=8; a ninth alloc_valid is ignored; release issue_ready -> entries issue in allocation order.
REQ-039 Allocate with src2 waiting on rob 9 while cdb_rob[0]=9 is valid in the same cycle -> entry is stored ready and issues without a further broadcast.
REQ-040 With 4 entries and issue_valid=1 stalled, assert flush -> next cycle count=0 and issue_valid=0; a new allocation then issues normally.
REQ-041 Assert rst low mid-stream with 5 entries -> outputs reach reset values immediately without a clock edge; no stale issue after release.
